// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round-function helpers.
// Used by the iterative encryptor and its key-step sub-module.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_fsm_t;

    // Forward S-box. Element 0 occupies the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t t;
        for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return t;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return t;
    endfunction

    function automatic aes_word_t mix_word(input aes_word_t w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t t;
        for (int c = 0; c < 4; c++) t[127-32*c -: 32] = mix_word(s[127-32*c -: 32]);
        return t;
    endfunction

    function automatic aes_state_t add_round_key(input aes_state_t s, input aes_state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Block-in / ciphertext-out valid/ready bundle for aes_encrypt_iter.
// master = host/buffer side, slave = engine side.
interface aes_encrypt_iter_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    aes_state_t key;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;

    modport master (
        output in_valid, in_data, key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: current round key + rcon -> next round key.
// Purely combinational; four S-box lookups on the rotated last word.
module aes_key_step
    import aes_pkg::*;
(
    input  aes_state_t rkey,
    input  logic [7:0] rcon,
    output aes_state_t next_key
);

    aes_word_t w0, w1, w2, w3;
    aes_word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rkey;

    assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one shared round datapath, round keys derived on the fly.
// Optional AES_ENC_LAST_KEY_OUT_EN exposes the round-10 key as last_key.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_encrypt_iter_if.slave    bus
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output aes_state_t           last_key
`endif
);

    aes_fsm_t   fsm;
    aes_state_t state_reg;
    aes_state_t rkey_reg;
    logic [7:0] rcon;
    logic [3:0] rnd;
    logic       out_valid_q;

    aes_state_t next_key;
    aes_state_t shifted;
    aes_state_t mixed;
    logic       accept;

    aes_key_step u_key_step (
        .rkey     (rkey_reg),
        .rcon     (rcon),
        .next_key (next_key)
    );

    assign shifted = shift_rows(sub_bytes(state_reg));
    assign mixed   = mix_columns(shifted);

    // A finished block can hand off and a new one load on the same edge.
    assign bus.in_ready  = (fsm == IDLE) || ((fsm == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_reg;

`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign last_key = rkey_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well, so out_data and last_key read zero after reset.
        if (!rst_n) begin
            fsm         <= IDLE;
            state_reg   <= '0;
            rkey_reg    <= '0;
            rcon        <= '0;
            rnd         <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments, so every register here updates from pre-edge values.
            state_reg   <= add_round_key(bus.in_data, bus.key);
            rkey_reg    <= bus.key;
            rcon        <= RCON_INIT;
            rnd         <= 4'd1;
            fsm         <= ROUND;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm)
                ROUND: begin
                    state_reg <= add_round_key(mixed, next_key);
                    rkey_reg  <= next_key;
                    rcon      <= xtime(rcon);
                    rnd       <= rnd + 4'd1;
                    if (rnd == 4'(NR - 1)) fsm <= FINAL;
                end
                FINAL: begin
                    state_reg   <= add_round_key(shifted, next_key);
                    rkey_reg    <= next_key;
                    fsm         <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: byte-level AES reference model plus a
// per-cycle compare process; last_key checks are active with AES_ENC_LAST_KEY_OUT_EN.
module tb_aes_encrypt_iter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_encrypt_iter_if bus_if ();
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key;
`endif

    aes_encrypt_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        ,
        .last_key (last_key)
`endif
    );

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LK_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LK_C   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (GF(2^8) arithmetic, byte arrays) ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [7:0]  st [16];
        logic [7:0]  tmp [16];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_m[st[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) tmp[row+4*c] = st[row+4*((c+row)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    st[4*c]   = gmul(tmp[4*c], 2) ^ gmul(tmp[4*c+1], 3) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 2) ^ gmul(tmp[4*c+2], 3) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 2) ^ gmul(tmp[4*c+3], 3);
                    st[4*c+3] = gmul(tmp[4*c], 3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 2);
                end else begin
                    for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) st[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
        lk = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- per-cycle compare process ----------------
    // age = clock edges since the block was accepted; -1 when no block is held.
    int           age = -1;
    int           cyc = 0;
    logic [127:0] exp_ct, exp_lk;
    logic [127:0] got_q [$];
    logic [127:0] got_lk_q [$];
    int           fire_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic exp_in_ready;
        if (!rst_n) age = -1;
        exp_in_ready = (age < 0) || (age >= 10 && bus_if.out_ready);
        check("out_valid", bus_if.out_valid, age >= 10);
        check("in_ready", bus_if.in_ready, exp_in_ready);
        if (age >= 10) begin
            check("out_data", bus_if.out_data, exp_ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
            check("last_key", last_key, exp_lk);
`endif
        end
        if (rst_n) begin
            if (age >= 10 && bus_if.out_ready) begin
                got_q.push_back(bus_if.out_data);
`ifdef AES_ENC_LAST_KEY_OUT_EN
                got_lk_q.push_back(last_key);
`endif
                fire_q.push_back(cyc);
                age = -1;
            end
            if (bus_if.in_valid && exp_in_ready) begin
                aes_ref(bus_if.in_data, bus_if.key, exp_ct, exp_lk);
                age = 0;
            end else if (age >= 0 && age < 10) begin
                age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = pt;
        bus_if.key      = k;
        @(negedge clk);
        while (!bus_if.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", bus_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_fire(input int n);
        int k = 0;
        while (got_q.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("fire_timeout", got_q.size(), n);
        #1;
    endtask

    task automatic expect_block(input string name, input logic [127:0] ct, input logic [127:0] lk);
        if (got_q.size() > 0) check(name, got_q.pop_front(), ct);
        else check({name, "_missing"}, 0, 1);
`ifdef AES_ENC_LAST_KEY_OUT_EN
        if (got_lk_q.size() > 0) check({name, "_last_key"}, got_lk_q.pop_front(), lk);
        else check({name, "_last_key_missing"}, 0, 1);
`else
        if (lk === 'x) check({name, "_lk_arg"}, lk, 0);
`endif
    endtask

    initial begin
        logic [127:0] m_ct, m_lk, snap;
        int n;

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.key       = '0;
        bus_if.out_ready = 1'b1;

        build_sbox();
        aes_ref(PT_B, KEY_B, m_ct, m_lk);
        check("model_ct_B", m_ct, CT_B);
        check("model_lk_B", m_lk, LK_B);
        aes_ref(PT_C, KEY_C, m_ct, m_lk);
        check("model_ct_C1", m_ct, CT_C);
        check("model_lk_C1", m_lk, LK_C);

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_data", bus_if.out_data, 0);
        check("reset_in_ready", bus_if.in_ready, 1);
`ifdef AES_ENC_LAST_KEY_OUT_EN
        check("reset_last_key", last_key, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single blocks: FIPS-197 B and C.1
        send(PT_B, KEY_B);
        wait_fire(1);
        expect_block("ct_B", CT_B, LK_B);
        send(PT_C, KEY_C);
        wait_fire(1);
        expect_block("ct_C1", CT_C, LK_C);

        // Back-to-back: second block accepted on the DONE edge, outputs 11 cycles apart
        fire_q.delete();
        send(PT_B, KEY_B);
        send(PT_C, KEY_C);
        wait_fire(2);
        expect_block("b2b_B", CT_B, LK_B);
        expect_block("b2b_C1", CT_C, LK_C);
        if (fire_q.size() == 2) check("b2b_spacing", fire_q[1] - fire_q[0], 11);
        else check("b2b_fire_count", fire_q.size(), 2);

        // Backpressure with a new block waiting
        bus_if.out_ready = 1'b0;
        send(PT_C, KEY_C);
        n = 0;
        while (!bus_if.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", bus_if.out_valid, 1);
        snap = bus_if.out_data;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = PT_B;
        bus_if.key      = KEY_B;
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold_data", bus_if.out_data, snap);
        check("bp_in_ready", bus_if.in_ready, 0);
        check("bp_no_fire", got_q.size(), 0);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("bp_single_handshake", got_q.size(), 1);
        expect_block("bp_C1", CT_C, LK_C);
        wait_fire(1);
        expect_block("bp_then_B", CT_B, LK_B);

        // Inputs toggled while rounds run must not disturb the block
        send(PT_B, KEY_B);
        for (int i = 0; i < 4; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
            bus_if.key      = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        wait_fire(1);
        expect_block("toggle_B", CT_B, LK_B);

        // Reset at round 5 discards the block
        send(PT_B, KEY_B);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus_if.out_valid, 0);
        check("rst_mid_in_ready", bus_if.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_output", got_q.size(), 0);
        send(PT_C, KEY_C);
        wait_fire(1);
        expect_block("post_rst_C1", CT_C, LK_C);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
